posit_run_cnt: RTL and testbench
================================

# posit_run_cnt

Pipelined, parametrised leading-run counter for the posit FPU front end. It counts the leading run of identical bits in a posit body (sign bit excluded): leading zeros, leading ones, or a regime run that matches the MSB. Valid/ready handshaking and a fixed two-stage pipeline let the posit decode and normalise paths stream operands at one per clock without a wide single-cycle priority encoder.

## Interface
Parameters:
- PSTWID, `PSTWID (positConfig.sv): posit width. Counted field N = PSTWID-1 bits. Legal range 8..128.
- TAGW, 4: width of sideband tag carried alongside each operand.
- Derived, not overridable: CW = $clog2(PSTWID); NC = ceil(N/8) chunks.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- flush_i, input, 1: synchronous pipeline clear.
- i_valid, input, 1: operand valid.
- i_ready, output, 1: block can accept an operand.
- i_data, input, N: field to scan; MSB is scanned first.
- i_mode, input, 2: 0 = leading zeros, 1 = leading ones, 2 = regime (run of bits equal to i_data[N-1]), 3 = reserved (treated as 2).
- i_tag, input, TAGW: passed through unchanged.
- o_valid, output, 1: result valid.
- o_ready, input, 1: downstream accepts the result.
- o_count, output, CW: run length, 0..N.
- o_all, output, 1: the entire field is the run (o_count == N).
- o_rbit, output, 1: run bit value (0 for mode 0, 1 for mode 1, i_data[N-1] for modes 2 and 3).
- o_tag, output, TAGW: tag of this result.

## Operation
- Run bit rb is chosen by mode. Stage 1 forms x = i_data ^ {N{rb}}, so the run always becomes a run of zeros.
- x is right-padded to NC*8 bits with ones. Padding never extends a run, so the count saturates at N and is never inflated.
- Stage 1 (S1) registers, per chunk c, z[c] (leading zeros of the chunk, 0..8), plus rb, the tag, and the mode-independent all-zero flag.
- Stage 2 (S2) registers:
  - o_count = 8*k + z[k], where k is the first chunk (MSB side) with z[k] < 8.
  - If no such chunk exists, o_count = N and o_all = 1.
  - o_all = (o_count == N) in every case.
- Arithmetic is unsigned CW bits. No overflow is possible because N ≤ 2^CW - 1.
- Mode 1 with i_data all ones gives o_count = N, o_all = 1, o_rbit = 1.

Handshake and elastic pipeline:
- S2 advances when !s2_valid | o_ready.
- S1 advances into S2 when s1_valid and S2 advances.
- i_ready = !s1_valid | (S2 advances). It is combinational from o_ready and adds no bubble.
- An input is accepted on a clock edge where i_valid & i_ready.
- While o_valid & !o_ready, o_count, o_all, o_rbit and o_tag are held stable.
- Order is preserved. Capacity is 2 operands.
- Simultaneous accept and emit in one cycle is permitted; throughput is 1 per clock.

Flush and reset:
- flush_i clears s1_valid and s2_valid on the next edge. An input presented in the same cycle is dropped, even if i_ready = 1.
- flush_i has priority over accept.
- rst_ni low: s1_valid = s2_valid = 0 immediately. o_valid = 0, o_count = 0, o_all = 0, o_rbit = 0, o_tag = 0.
- Operands in flight when reset asserts are lost. i_ready = 1 after reset.

## Timing
- Latency: 2 cycles from acceptance to o_valid, when unstalled.
- No combinational path from i_data to any output.
- The only comb path input→output is o_ready → i_ready.
- Critical path is S2's NC-way priority select plus CW-bit add. For PSTWID = 128 (NC = 16) this must close at the FPU clock.

## Structure
- Shared package posit_pkg holds:
  - enum run_mode_e {RUN_LZ, RUN_LO, RUN_REG};
  - function chunks(n) = (n+7)/8.
- PSTWID stays sourced from positConfig.sv.
- One sub-module, posit_clz8: combinational 8-bit leading-zero count, output 0..8. It is instantiated NC times in S1.

## Test plan (PSTWID = 32, N = 31)
- Mode 0, i_data = 31'h0000_0001 → o_count = 30, o_all = 0, o_rbit = 0, exactly 2 cycles after accept.
- Mode 0, i_data = 0 → o_count = 31, o_all = 1. Mode 1, i_data = 31'h7FFF_FFFF → o_count = 31, o_all = 1, o_rbit = 1.
- Mode 2, i_data = 31'h7800_0000 → o_count = 4, o_rbit = 1. Mode 2, i_data = 31'h0FFF_FFFF → o_count = 3, o_rbit = 0.
- Backpressure: o_ready = 0, stream 3 operands with tags 1, 2, 3.
  - i_ready falls after 2 accepts.
  - Outputs stay stable while stalled.
  - Raising o_ready yields tags 1, 2, 3 in order, with no loss or duplication.
- Back-to-back streaming of 100 random operands in random modes with o_ready = 1: one result per cycle, each matching the reference count.
- flush_i asserted with 2 operands in flight and i_valid = 1 → next cycle o_valid = 0, no stale result appears. Repeat with rst_ni pulsed mid-stream: all outputs are 0 while reset is asserted.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit front-end definitions: run modes and chunking helper.
package posit_pkg;

  // Width of an 8-bit leading-zero count (0..8).
  localparam int unsigned CLZ8_W = 4;

  typedef enum logic [1:0] {
    RUN_LZ  = 2'd0,
    RUN_LO  = 2'd1,
    RUN_REG = 2'd2
  } run_mode_e;

  // Number of 8-bit chunks needed to cover an n-bit field.
  function automatic int unsigned chunks(input int unsigned n);
    return (n + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/posit_clz8.sv
// Combinational leading-zero count of one byte, result 0..8.
module posit_clz8
  import posit_pkg::*;
(
  input  logic [7:0]        d,
  output logic [CLZ8_W-1:0] z
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    z = CLZ8_W'(8);
    for (int i = 0; i < 8; i++) begin
      if (d[i]) z = CLZ8_W'(7 - i);
    end
  end

endmodule

// File: rtl/posit_run_cnt.sv
// Two-stage elastic leading-run counter for the posit decode/normalise paths.
`ifndef PSTWID
`define PSTWID 32
`endif

module posit_run_cnt
  import posit_pkg::*;
#(
  parameter int unsigned PSTWID = `PSTWID,
  parameter int unsigned TAGW   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [PSTWID-2:0]         i_data,
  input  logic [1:0]                i_mode,
  input  logic [TAGW-1:0]           i_tag,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [$clog2(PSTWID)-1:0] o_count,
  output logic                      o_all,
  output logic                      o_rbit,
  output logic [TAGW-1:0]           o_tag
);

  localparam int unsigned N  = PSTWID - 1;
  localparam int unsigned CW = $clog2(PSTWID);
  localparam int unsigned NC = chunks(N);
  localparam int unsigned PW = NC * 8;

  logic                          rb_c;
  logic [N-1:0]                  x_c;
  logic [PW-1:0]                 xp_c;
  logic [NC-1:0][CLZ8_W-1:0]     z_c;
  logic                          s2_adv_c;
  logic                          accept_c;
  logic [CW-1:0]                 cnt_c;
  logic                          all_c;

  logic                          s1_valid;
  logic [NC-1:0][CLZ8_W-1:0]     s1_z;
  logic                          s1_rb;
  logic                          s1_allz;
  logic [TAGW-1:0]               s1_tag;

  // Handshake: S2 drains when empty or consumed; i_ready sees o_ready combinationally.
  always_comb begin
    s2_adv_c = !o_valid || o_ready;
    i_ready  = !s1_valid || s2_adv_c;
    accept_c = i_valid && i_ready && !flush_i;
  end

  // Pick the run bit and invert so the run always becomes a run of zeros.
  always_comb begin
    case (i_mode)
      RUN_LZ:  rb_c = 1'b0;
      RUN_LO:  rb_c = 1'b1;
      default: rb_c = i_data[N-1];
    endcase
    x_c = i_data ^ {N{rb_c}};
  end

  // Pad with ones on the LSB side so padding can never lengthen a run.
  if (PW > N) begin : g_pad
    assign xp_c = {x_c, {(PW - N){1'b1}}};
  end else begin : g_nopad
    assign xp_c = x_c;
  end

  for (genvar c = 0; c < NC; c++) begin : g_chunk
    posit_clz8 u_clz8 (
      .d (xp_c[PW-1-8*c -: 8]),
      .z (z_c[c])
    );
  end

  // Stage 1: per-chunk counts, run bit, tag and the all-zero flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_z     <= '0;
      s1_rb    <= 1'b0;
      s1_allz  <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (accept_c) begin
        s1_valid <= 1'b1;
      end else if (s2_adv_c) begin
        s1_valid <= 1'b0;
      end
      if (accept_c) begin
        s1_z    <= z_c;
        s1_rb   <= rb_c;
        s1_allz <= ~|x_c;
        s1_tag  <= i_tag;
      end
    end
  end

  // Priority select of the first non-full chunk, then offset add.
  always_comb begin
    cnt_c = CW'(N);
    for (int k = NC - 1; k >= 0; k--) begin
      if (s1_z[k] != CLZ8_W'(8)) cnt_c = CW'(8 * k) + CW'(s1_z[k]);
    end
    if (s1_allz) cnt_c = CW'(N);
    all_c = (cnt_c == CW'(N));
  end

  // Stage 2: registered result, held while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_valid <= 1'b0;
      o_count <= '0;
      o_all   <= 1'b0;
      o_rbit  <= 1'b0;
      o_tag   <= '0;
    end else begin
      if (flush_i) begin
        o_valid <= 1'b0;
      end else if (s2_adv_c) begin
        o_valid <= s1_valid;
      end
      if (!flush_i && s2_adv_c && s1_valid) begin
        o_count <= cnt_c;
        o_all   <= all_c;
        o_rbit  <= s1_rb;
        o_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_posit_run_cnt.sv
// Self-checking bench for posit_run_cnt with a bit-scanning reference model.
module tb_posit_run_cnt;

  localparam int unsigned PSTWID = 32;
  localparam int unsigned N      = PSTWID - 1;
  localparam int unsigned CW     = 5;
  localparam int unsigned TAGW   = 4;

  typedef struct packed {
    logic [CW-1:0]   cnt;
    logic            all;
    logic            rb;
    logic [TAGW-1:0] tag;
  } res_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            i_valid;
  logic            i_ready;
  logic [N-1:0]    i_data;
  logic [1:0]      i_mode;
  logic [TAGW-1:0] i_tag;
  logic            o_valid;
  logic            o_ready;
  logic [CW-1:0]   o_count;
  logic            o_all;
  logic            o_rbit;
  logic [TAGW-1:0] o_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  posit_run_cnt #(.PSTWID(PSTWID), .TAGW(TAGW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_count (o_count),
    .o_all   (o_all),
    .o_rbit  (o_rbit),
    .o_tag   (o_tag)
  );

  // Reference: walk bits from the MSB while they equal the run bit.
  function automatic res_t ref_run(input logic [N-1:0] d, input logic [1:0] m, input logic [TAGW-1:0] t);
    res_t r;
    int   cnt;
    logic rb;
    rb  = (m == 2'd0) ? 1'b0 : (m == 2'd1) ? 1'b1 : d[N-1];
    cnt = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i] !== rb) break;
      cnt++;
    end
    r.cnt = CW'(cnt);
    r.all = (cnt == N);
    r.rb  = rb;
    r.tag = t;
    return r;
  endfunction

  function automatic logic [N-1:0] rand_data();
    logic [31:0] r;
    logic [N-1:0] d;
    r = $urandom;
    d = N'(r >> $urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) d = ~d;
    if ($urandom_range(0, 19) == 0) d = '0;
    if ($urandom_range(0, 19) == 0) d = '1;
    return d;
  endfunction

  function automatic res_t dut_res();
    return {o_count, o_all, o_rbit, o_tag};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; i_valid = 1'b0; i_data = '0;
    i_mode = 2'd0; i_tag = '0; o_ready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({o_valid, o_count, o_all, o_rbit, o_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {o_valid, o_count, o_all, o_rbit, o_tag});
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got i_ready=%b o_valid=%b expected 1/0", i_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] d_tab [5];
    logic [1:0]   m_tab [5];
    res_t         e_tab [5];
    d_tab = '{31'h0000_0001, 31'h0000_0000, 31'h7FFF_FFFF, 31'h7800_0000, 31'h0FFF_FFFF};
    m_tab = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    e_tab = '{{5'd30, 1'b0, 1'b0, 4'd1}, {5'd31, 1'b1, 1'b0, 4'd2}, {5'd31, 1'b1, 1'b1, 4'd3},
              {5'd4, 1'b0, 1'b1, 4'd4}, {5'd3, 1'b0, 1'b0, 4'd5}};
    o_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      @(posedge clk_i); #1;
      i_valid = 1'b1; i_data = d_tab[v]; i_mode = m_tab[v]; i_tag = TAGW'(v + 1);
      @(posedge clk_i); #1 i_valid = 1'b0;
      @(negedge clk_i);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_early_%0d: got o_valid=%b expected 0", v, o_valid);
      end
      @(negedge clk_i);
      checks++;
      if (o_valid !== 1'b1 || dut_res() !== e_tab[v]) begin
        errors++;
        $display("FAIL directed_%0d: got valid=%b res=%h expected valid=1 res=%h", v, o_valid, dut_res(), e_tab[v]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t held;
    res_t exp_q[$];
    logic [TAGW-1:0] got[$];
    logic [N-1:0] d;
    logic [1:0] m;
    bit acc;
    @(posedge clk_i); #1;
    o_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      d = rand_data(); m = 2'($urandom_range(0, 3));
      i_valid = 1'b1; i_data = d; i_mode = m; i_tag = TAGW'(t);
      exp_q.push_back(ref_run(d, m, TAGW'(t)));
      if (t < 3) begin
        @(posedge clk_i); #1;
      end
    end
    @(negedge clk_i);
    checks++;
    if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_tag !== 4'd1) begin
      errors++;
      $display("FAIL bp_full: got i_ready=%b o_valid=%b o_tag=%0d expected 0/1/1", i_ready, o_valid, o_tag);
    end
    held = dut_res();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (dut_res() !== held || o_valid !== 1'b1 || i_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable_%0d: got %h valid=%b ready=%b expected %h/1/0", c, dut_res(), o_valid, i_ready, held);
      end
    end
    @(posedge clk_i); #1 o_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      @(negedge clk_i);
      acc = i_valid && i_ready;
      if (o_valid && o_ready) begin
        got.push_back(o_tag);
        checks++;
        if (exp_q.size() == 0 || dut_res() !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_result: got %h expected %h", dut_res(), (exp_q.size() != 0) ? exp_q[0] : res_t'('0));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk_i); #1;
      if (acc) i_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d results expected 3", got.size());
    end else begin
      for (int t = 0; t < 3; t++) begin
        checks++;
        if (got[t] !== TAGW'(t + 1)) begin
          errors++;
          $display("FAIL bp_order_%0d: got tag %0d expected %0d", t, got[t], t + 1);
        end
      end
    end
    i_valid = 1'b0;
  endtask

  // Streams n random operands; rand_hs randomises both handshakes, else full rate.
  task automatic test_stream(input int n, input bit rand_hs);
    res_t exp_q[$];
    res_t held;
    bit   stalled;
    int   sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rcvd < n && cyc < n * 8 + 40) begin
      i_valid = (sent < n) && (!rand_hs || $urandom_range(0, 3) != 0);
      i_data  = rand_data();
      i_mode  = 2'($urandom_range(0, 3));
      i_tag   = TAGW'($urandom);
      o_ready = !rand_hs || ($urandom_range(0, 2) != 0);
      @(negedge clk_i);
      cyc++;
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || dut_res() !== held) begin
          errors++;
          $display("FAIL stream_hold: got valid=%b res=%h expected 1/%h", o_valid, dut_res(), held);
        end
      end
      if (o_valid && o_ready) begin
        checks++;
        if (exp_q.size() == 0 || dut_res() !== exp_q[0]) begin
          errors++;
          $display("FAIL stream_result_%0d: got %h expected %h", rcvd, dut_res(), (exp_q.size() != 0) ? exp_q[0] : res_t'('0));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rcvd++;
      end
      if (i_valid && i_ready) begin
        exp_q.push_back(ref_run(i_data, i_mode, i_tag));
        sent++;
      end
      stalled = o_valid && !o_ready;
      held    = dut_res();
      @(posedge clk_i); #1;
    end
    i_valid = 1'b0; o_ready = 1'b1;
    checks++;
    if (rcvd != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_done: got %0d results (%0d pending) expected %0d", rcvd, exp_q.size(), n);
    end
    if (!rand_hs) begin
      checks++;
      if (cyc != n + 2) begin
        errors++;
        $display("FAIL stream_rate: got %0d cycles expected %0d", cyc, n + 2);
      end
    end
  endtask

  task automatic test_flush();
    res_t e;
    o_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      i_valid = 1'b1; i_data = rand_data(); i_mode = 2'd0; i_tag = TAGW'(t);
      if (t == 3) flush_i = 1'b1;
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0; i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty_%0d: got o_valid=%b tag=%0d expected 0", c, o_valid, o_tag);
      end
    end
    @(posedge clk_i); #1;
    i_valid = 1'b1; i_data = 31'h00FF_0000; i_mode = 2'd2; i_tag = 4'd9;
    e = ref_run(i_data, i_mode, i_tag);
    @(posedge clk_i); #1 i_valid = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    checks++;
    if (o_valid !== 1'b1 || dut_res() !== e) begin
      errors++;
      $display("FAIL flush_recover: got valid=%b res=%h expected 1/%h", o_valid, dut_res(), e);
    end
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      i_valid = 1'b1; i_data = rand_data(); i_mode = 2'($urandom_range(0, 3)); i_tag = TAGW'(t + 4);
      @(posedge clk_i); #1;
    end
    #2 rst_ni = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({o_valid, o_count, o_all, o_rbit, o_tag} !== '0 || i_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_%0d: got %h i_ready=%b expected 0/1", c, {o_valid, o_count, o_all, o_rbit, o_tag}, i_ready);
      end
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale_%0d: got o_valid=%b expected 0", c, o_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    @(posedge clk_i); #1;
    test_stream(100, 1'b0);
    test_stream(150, 1'b1);
    test_flush();
    @(posedge clk_i); #1;
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
